vga_line_fetcher: RTL

VGA_LINE_FETCHER -- requirements
Module: vga_line_fetcher

---
 rtl/vga_line_fetcher.sv | 111 +++++++++++
 1 files changed

// File: rtl/vga_line_fetcher.sv
// vga_line_fetcher: ping-pong line buffer that prefetches the next scanline from memory and streams RGB332 pixels.
module vga_line_fetcher #(
    parameter int FB_BASE = 0,
    parameter int ADDR_W  = 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pix_stb,
    input  logic              i_active,
    input  logic              i_screenend,
    input  logic [9:0]        i_x,
    input  logic [8:0]        i_y,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_data,
    output logic [2:0]        o_r,
    output logic [2:0]        o_g,
    output logic [1:0]        o_b,
    output logic              o_underrun
);
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    state_t state, state_n;
    logic active_q, rise, fall, start, restart, last;
    logic sel, sel_n, disp_ok, ok_n, pend;
    logic [7:0] w, pix, pix_n;
    logic [8:0] line;
    logic [ADDR_W-1:0] addr, new_base, pend_base;
    logic [31:0] rd;
    logic [31:0] lb [2][160];
    assign rise = i_pix_stb & i_active & ~active_q;
    assign fall = i_pix_stb & ~i_active & active_q;
    assign start = (i_screenend & (state != FETCH)) | (fall & (i_y < 9'd479));
    assign line = (i_screenend && state != FETCH) ? 9'd0 : i_y + 9'd1;
    assign new_base = ADDR_W'(FB_BASE) + (ADDR_W'(line) << 7) + (ADDR_W'(line) << 5);
    // an ack taken while a new trigger is waiting ends the old line and restarts at word 0
    assign restart = (state == FETCH) & i_mem_ack & (start | pend);
    assign last = (state == FETCH) & i_mem_ack & (w == 8'd159) & ~restart;
    // the swap and the valid flag take effect on the very strobe that sees the rising edge
    assign sel_n = sel ^ (rise & (state == DONE));
    assign ok_n = rise ? (state == DONE) : disp_ok;
    assign rd = lb[sel_n][i_x[9:2]];
    assign pix_n = (i_active & ok_n) ? rd[{i_x[1:0], 3'b000} +: 8] : 8'd0;
    assign o_r = pix[7:5];
    assign o_g = pix[4:2];
    assign o_b = pix[1:0];

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_n;
    end

    // FSM next state: a fetch runs to its last word, a trigger starts one, a rise in DONE hands the line over
    always_comb begin
        state_n = (state == FETCH) ? (last ? DONE : FETCH) :
                  start ? FETCH :
                  (state == DONE && rise) ? IDLE : state;
    end

    // FSM outputs: request follows the FETCH state so reset withdraws it at once
    always_comb begin
        o_mem_req = (state == FETCH);
        o_mem_addr = addr;
    end

    // word counter, request address and a deferred restart held until the outstanding word is acked
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w <= 8'd0;
            addr <= '0;
            pend <= 1'b0;
            pend_base <= '0;
        end else if (state != FETCH) begin
            if (start) begin
                w <= 8'd0;
                addr <= new_base;
            end
            pend <= 1'b0;
        end else if (i_mem_ack) begin
            w <= restart ? 8'd0 : w + 8'd1;
            addr <= start ? new_base : pend ? pend_base : addr + 1'b1;
            pend <= 1'b0;
        end else if (start) begin
            pend <= 1'b1;
            pend_base <= new_base;
        end
    end

    // fill buffer write; contents survive reset
    always_ff @(posedge i_clk) begin
        if (state == FETCH && i_mem_ack && !restart) lb[~sel][w] <= i_mem_data;
    end

    // pixel pipeline, buffer select and sticky underrun, all advancing on the pixel strobe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_q <= 1'b0;
            sel <= 1'b0;
            disp_ok <= 1'b0;
            pix <= 8'd0;
            o_underrun <= 1'b0;
        end else if (i_pix_stb) begin
            active_q <= i_active;
            sel <= sel_n;
            disp_ok <= ok_n;
            pix <= pix_n;
            o_underrun <= o_underrun | (rise & (state != DONE));
        end
    end
endmodule
